window_min_max_tracker: RTL
===========================

# window_min_max_tracker

Downstream consumer of the 4-bit magnitude comparator. It accepts a window of 4-bit samples over a valid/ready handshake and tracks the window's running maximum, minimum, first index of the maximum, and repeat hits of the maximum. All ordering decisions come from two `mag_comp` instances: (sample vs max_reg) and (sample vs min_reg). Results are presented once per window through a valid/ready output handshake.

## Interface
- `WINDOW`, default 8: samples per window; legal range 2..16.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  begin a window; sampled only in IDLE.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  4  unsigned sample.
- `in_ready`  out  1  block can accept a sample; high only in TRACK.
- `out_valid`  out  1  window results are valid; high only in REPORT.
- `out_ready`  in  1  consumer accepts the results.
- `out_max`  out  4  window maximum.
- `out_min`  out  4  window minimum.
- `out_max_idx`  out  4  index (0-based) of the first occurrence of the maximum.
- `out_eq_cnt`  out  4  count of samples after the first that equal the current maximum at their arrival.

## Operation
- FSM states: IDLE, TRACK, REPORT. Reset state is IDLE.
- IDLE:
  - `in_ready`=0, `out_valid`=0.
  - `start`=1 -> TRACK; `cnt` is cleared to 0.
- TRACK:
  - `in_ready`=1. A sample is accepted on any edge with `in_valid`&`in_ready`.
  - If `cnt`==0: max_reg=min_reg=`in_data`, idx=0, eq=0.
  - Otherwise, using the comparator flags:
    - GT(data, max_reg): max_reg=data, idx=`cnt`, eq=0.
    - EQ(data, max_reg): eq=eq+1.
    - LT(data, min_reg): min_reg=data.
    - Max and min updates are evaluated independently in the same cycle.
  - `cnt` increments on every accept.
  - The accept that brings `cnt` to `WINDOW` -> REPORT.
  - `start` is ignored.
- REPORT:
  - `out_valid`=1; outputs are stable.
  - `out_valid`&`out_ready` -> IDLE.
  - `start` in the same cycle is ignored; it must be asserted again in IDLE.
- Width rules:
  - `cnt` is 5 bits internally.
  - `idx` and `eq` are 4 bits; `eq` cannot exceed `WINDOW`-1 (≤15), so no saturation is needed.
- `out_*` data outputs are the internal registers directly. They hold their last value through IDLE until the first accept of the next window.
- `in_valid` outside TRACK is ignored; no sample is lost or counted.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, `in_ready`=0, `out_valid`=0, `out_max`=0, `out_min`=0, `out_max_idx`=0, `out_eq_cnt`=0, `cnt`=0.
- `in_ready` and `out_valid` are decoded from the registered state only, with no combinational path from inputs.
- `start` at edge N -> `in_ready`=1 from cycle N+1.
- Final accept at edge N -> `out_valid`=1 in cycle N+1, with final values already on `out_*`.
- Minimum window duration is `WINDOW` cycles plus 1 REPORT cycle plus 1 IDLE cycle before the next window can start.
- Reset asserted mid-window or mid-REPORT aborts immediately to the reset values. No partial result is emitted.

## Configuration
- `TRACKER_EQ_CNT_EN` defined: the equal-hit counter and the third comparator usage are compiled in, and `out_eq_cnt` behaves as specified.
- `TRACKER_EQ_CNT_EN` undefined: no `eq` register is built, and `out_eq_cnt` is tied to 4'd0. All other behaviour is identical.

## Test plan
- `WINDOW`=4, start, samples 5,9,2,9 back-to-back -> REPORT with max=9, min=2, idx=1, eq=1 (0 without the macro). `out_valid` rises one cycle after the 4th accept.
- `WINDOW`=4, samples 15,15,15,15 -> max=15, min=15, idx=0, eq=3.
- `WINDOW`=4, samples 0,7,15,3 with `in_valid` gapped every other cycle -> only 4 accepts counted; max=15, idx=2, min=0, eq=0.
- Hold `out_ready`=0 for 5 cycles in REPORT -> `out_valid` and `out_*` stay stable. Then assert `out_ready` together with `start` -> IDLE, and no new window starts until `start` is reasserted.
- Assert `rst` after the 2nd accept of a window -> all outputs 0 and IDLE immediately. A new window 1,2 (`WINDOW`=2) then reports max=2, min=1, idx=1.
- `in_valid`=1 with `in_data`=12 while in IDLE for 3 cycles, then start and samples 4,8 (`WINDOW`=2) -> max=8, min=4; the value 12 never appears.

Source files
------------

// File: rtl/window_min_max_tracker.sv
// Per-window max/min/first-max-index tracker fed by 4-bit magnitude comparators.
// Optional equal-hit counter compiled in with `define TRACKER_EQ_CNT_EN.

module mag_comp (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gt_c,
  output logic       eq_c,
  output logic       lt_c
);
  assign gt_c = (a > b);
  assign eq_c = (a == b);
  assign lt_c = (a < b);
endmodule

module window_min_max_tracker #(
  parameter int unsigned WINDOW = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_max,
  output logic [3:0] out_min,
  output logic [3:0] out_max_idx,
  output logic [3:0] out_eq_cnt
);
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned DATA_W = 4;

  typedef enum logic [1:0] {IDLE, TRACK, REPORT} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   max_reg, min_reg, idx_reg;
  logic                max_gt, max_eq, max_lt;
  logic                min_gt, min_eq, min_lt;
  logic                start_c, accept_c, last_c;
  logic                unused_flags_c;

  mag_comp u_cmp_max (.a(in_data), .b(max_reg), .gt_c(max_gt), .eq_c(max_eq), .lt_c(max_lt));
  mag_comp u_cmp_min (.a(in_data), .b(min_reg), .gt_c(min_gt), .eq_c(min_eq), .lt_c(min_lt));

  assign start_c  = (state == IDLE) && start;
  assign accept_c = (state == TRACK) && in_valid;
  assign last_c   = accept_c && (cnt == CNT_W'(WINDOW - 1));

  // Handshake flags come straight from the state register.
  assign in_ready  = (state == TRACK);
  assign out_valid = (state == REPORT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = TRACK;
      TRACK:   if (last_c) state_next = REPORT;
      REPORT:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Max and min update independently; the first sample seeds both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      max_reg <= '0;
      min_reg <= '0;
      idx_reg <= '0;
    end else if (start_c) begin
      cnt <= '0;
    end else if (accept_c) begin
      cnt <= cnt + CNT_W'(1);
      if (cnt == '0) begin
        max_reg <= in_data;
        min_reg <= in_data;
        idx_reg <= '0;
      end else begin
        if (max_gt) begin
          max_reg <= in_data;
          idx_reg <= DATA_W'(cnt);
        end
        if (min_lt) min_reg <= in_data;
      end
    end
  end

`ifdef TRACKER_EQ_CNT_EN
  logic [DATA_W-1:0] eq_reg;

  // Repeat hits of the running max; reset whenever a new max arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eq_reg <= '0;
    end else if (!start_c && accept_c) begin
      if (cnt == '0 || max_gt) eq_reg <= '0;
      else if (max_eq)         eq_reg <= eq_reg + DATA_W'(1);
    end
  end

  assign out_eq_cnt     = eq_reg;
  assign unused_flags_c = ^{max_lt, min_gt, min_eq};
`else
  assign out_eq_cnt     = 4'd0;
  assign unused_flags_c = ^{max_lt, max_eq, min_gt, min_eq};
`endif

  assign out_max     = max_reg;
  assign out_min     = min_reg;
  assign out_max_idx = idx_reg;

endmodule
